// File: rtl/switch_pkg.sv
// Shared constants, helpers and types for the slide-switch debouncer.
//   DB_CYCLES_DEFAULT : default settle time in clk cycles (10 ms at CLK_HZ)
//   CLK_HZ            : nominal system clock frequency
//   DB_CYCLES_SIM     : short settle time used when simulating
//   clog2 / cnt_width : counter width derivation
//   chan_out_t        : per-channel registered result
package switch_pkg;

   localparam int unsigned CLK_HZ            = 50_000_000;
   localparam int unsigned DB_CYCLES_DEFAULT = 500_000;
   localparam int unsigned DB_CYCLES_SIM     = 4;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      logic [32:0]  pow;
      int unsigned  result;
      pow    = 33'd1;
      result = 0;
      while (pow < 33'(value)) begin
         pow    = pow << 1;
         result = result + 1;
      end
      return result;
   endfunction

   // Smallest width able to hold db_cycles-1, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned db_cycles);
      int unsigned w;
      w = clog2(db_cycles);
      return (w < 1) ? 1 : w;
   endfunction

   typedef struct packed {
      logic stable;
      logic rise;
      logic fall;
   } chan_out_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, persistence counter and
// rise/fall pulse generation.
//   clk, reset_n : clock, asynchronous active-low reset
//   raw          : asynchronous switch pin
//   status       : registered stable level plus one-cycle rise/fall pulses
//   pulse_c      : combinational next-cycle rise|fall, for the top-level OR
module debounce_channel
   import switch_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned CNT_W     = cnt_width(DB_CYCLES),
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      raw,
   output chan_out_t status,
   output logic      pulse_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             stable_nxt;
   logic             rise_nxt;
   logic             fall_nxt;

   // Filter: count an uninterrupted run of a differing level, accept it at CNT_MAX.
   always_comb begin
      cnt_nxt    = '0;
      stable_nxt = status.stable;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      if (sync2 != status.stable) begin
         // >= keeps the counter from ever wrapping past CNT_MAX
         if (cnt >= CNT_MAX) begin
            stable_nxt = sync2;
            rise_nxt   = sync2;
            fall_nxt   = ~sync2;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
      pulse_c = rise_nxt | fall_nxt;
   end

   // Synchroniser, counter and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1         <= RESET_VAL;
         sync2         <= RESET_VAL;
         cnt           <= '0;
         status.stable <= RESET_VAL;
         status.rise   <= 1'b0;
         status.fall   <= 1'b0;
      end else begin
         sync1         <= raw;
         sync2         <= sync1;
         cnt           <= cnt_nxt;
         status.stable <= stable_nxt;
         status.rise   <= rise_nxt;
         status.fall   <= fall_nxt;
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide-switch pins for the switch PIO in_port and flags
// level changes for the alarm-clock control logic.
//   clk, reset_n : 50 MHz clock, asynchronous active-low reset
//   sw_raw       : asynchronous switch pins
//   sw_stable    : debounced levels
//   sw_rise      : one-cycle pulse per channel on 0->1 of sw_stable
//   sw_fall      : one-cycle pulse per channel on 1->0 of sw_stable
//   sw_changed   : one-cycle pulse when any channel pulses
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int unsigned      WIDTH     = 2,
   parameter int unsigned      DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned      CNT_W     = cnt_width(DB_CYCLES),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   logic [WIDTH-1:0] pulse_c;

   // Independent filter per channel.
   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      chan_out_t status;

      debounce_channel #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W),
         .RESET_VAL (RESET_VAL[i])
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (sw_raw[i]),
         .status  (status),
         .pulse_c (pulse_c[i])
      );

      assign sw_stable[i] = status.stable;
      assign sw_rise[i]   = status.rise;
      assign sw_fall[i]   = status.fall;
   end

   // Registered from the channels' next-cycle pulses so it lines up with them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_changed <= 1'b0;
      end else begin
         sw_changed <= |pulse_c;
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=2, DB_CYCLES=4, RESET_VAL=0).
// The stimulus queues the expected {stable, rise, fall, changed} for every
// clock edge; an independent monitor pops and compares after each edge.
module tb_switch_debouncer;
   import switch_pkg::*;

   localparam int unsigned W  = 2;
   localparam int unsigned DB = DB_CYCLES_SIM;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] sw_raw  = 2'b11;
   logic [W-1:0] sw_stable;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;

   switch_debouncer #(
      .WIDTH     (W),
      .DB_CYCLES (DB),
      .RESET_VAL (2'b00)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .sw_stable  (sw_stable),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] v;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, act[6:0], req[6:0]);
      end
   endtask

   // Monitor: one expected record per clock edge, sampled 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, 32'({sw_stable, sw_rise, sw_fall, sw_changed}), 32'(e.v));
         end
      end
   end

   // Drive raw at a falling edge and queue the outputs expected after the next rising edge.
   task automatic cyc(input string tag, input logic [1:0] raw, input logic [1:0] st,
                      input logic [1:0] ri, input logic [1:0] fa, input logic ch);
      exp_t e;
      sw_raw = raw;
      e.v    = {st, ri, fa, ch};
      e.tag  = tag;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic hold(input string tag, input logic [1:0] raw, input logic [1:0] st, input int n);
      for (int i = 0; i < n; i++) cyc(tag, raw, st, 2'b00, 2'b00, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      @(negedge clk);
      check("reset_state", 32'({sw_stable, sw_rise, sw_fall, sw_changed}), 32'd0);

      // 1: raw=11 through reset; rise lands on the sixth edge after release
      hold("s1_in_reset", 2'b11, 2'b00, 2);
      reset_n = 1'b1;
      hold("s1_wait", 2'b11, 2'b00, 5);
      cyc("s1_rise", 2'b11, 2'b11, 2'b11, 2'b00, 1'b1);
      hold("s1_hold", 2'b11, 2'b11, 3);

      // 4: both channels fall together
      hold("s4_wait", 2'b00, 2'b11, 5);
      cyc("s4_fall", 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
      hold("s4_hold", 2'b00, 2'b00, 2);

      // 2: three-cycle glitch on channel 0 is rejected
      hold("s2_glitch", 2'b01, 2'b00, 3);
      hold("s2_after", 2'b00, 2'b00, 8);

      // 3: channel 1 bounces 1,0,1,0 then settles at 1
      cyc("s3_b1", 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("s3_b0", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("s3_b1", 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      cyc("s3_b0", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      hold("s3_wait", 2'b10, 2'b00, 5);
      cyc("s3_rise", 2'b10, 2'b10, 2'b10, 2'b00, 1'b1);
      hold("s3_hold", 2'b10, 2'b10, 2);

      // 5: channel 0 rises while channel 1 falls
      hold("s5_wait", 2'b01, 2'b10, 5);
      cyc("s5_both", 2'b01, 2'b01, 2'b01, 2'b10, 1'b1);
      hold("s5_hold", 2'b01, 2'b01, 2);

      // 6: return to 00, then reset while counting toward 01
      hold("s6_pre", 2'b00, 2'b01, 5);
      cyc("s6_fall", 2'b00, 2'b00, 2'b00, 2'b01, 1'b1);
      hold("s6_idle", 2'b00, 2'b00, 2);
      hold("s6_count", 2'b01, 2'b00, 4);
      reset_n = 1'b0;
      #1;
      check("s6_reset_now", 32'({sw_stable, sw_rise, sw_fall, sw_changed}), 32'd0);
      hold("s6_in_reset", 2'b01, 2'b00, 2);
      reset_n = 1'b1;
      hold("s6_wait", 2'b01, 2'b00, 5);
      cyc("s6_rise", 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
      hold("s6_hold", 2'b01, 2'b01, 2);

      // Asynchronous reset between clock edges with a non-zero stable level
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", 32'({sw_stable, sw_rise, sw_fall, sw_changed}), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Conditions raw slide-switch inputs before they reach the switch PIO's in_port on the Avalon bus.
- Each channel is synchronised into the clk domain through two flops.
- A per-channel counter filters out bounce and glitches.
- The block outputs a clean stable level per channel, plus one-cycle rise and fall pulses for the alarm-clock control logic.

Parameters:
WIDTH, 2, number of switch channels (must be >= 1).
DB_CYCLES, 500000, consecutive clk cycles a new level must persist before acceptance (10 ms at 50 MHz); must be >= 1.
CNT_W, 19, counter width; must satisfy 2**CNT_W > DB_CYCLES-1.
RESET_VAL, 0 (WIDTH bits), reset value of the synchroniser flops and of sw_stable.

Ports:
clk  input  1  system clock, 50 MHz.
reset_n  input  1  asynchronous, active-low reset.
sw_raw  input  WIDTH  asynchronous switch pins.
sw_stable  output  WIDTH  debounced level; drives the PIO in_port.
sw_rise  output  WIDTH  one-cycle pulse when sw_stable[i] goes 0->1.
sw_fall  output  WIDTH  one-cycle pulse when sw_stable[i] goes 1->0.
sw_changed  output  1  registered OR of (sw_rise | sw_fall), asserted in the same cycle as those pulses.

Behaviour:
- Reset (reset_n low, asynchronous):
  - sync1, sync2 and sw_stable are set to RESET_VAL.
  - All counters are set to 0.
  - sw_rise, sw_fall and sw_changed are set to 0.
  - No edge pulse is generated on reset release.
- Synchroniser: at each clk edge, sync1 <= sw_raw and sync2 <= sync1. All downstream logic sees only sync2.
- Per-channel filter, evaluated each cycle:
  - If sync2[i] == sw_stable[i]: cnt[i] <= 0.
  - If they differ and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If they differ and cnt[i] == DB_CYCLES-1: sw_stable[i] <= sync2[i], cnt[i] <= 0, and the matching rise or fall bit is set for exactly one cycle.
- Latency: let edge 0 be the first clk edge at which sync1 samples a new sw_raw level that then stays constant. sw_stable updates at edge DB_CYCLES+1, so the new value is visible after DB_CYCLES+2 edges. rise/fall/changed assert on that same edge.
- Glitch rejection: a level that differs for fewer than DB_CYCLES consecutive sync2 cycles never reaches sw_stable. The counter restarts from 0 on the first cycle sync2 matches sw_stable again.
- Bounce returning to the old level mid-count resets the count; only an uninterrupted run counts.
- Counter saturation: cnt never exceeds DB_CYCLES-1 and never wraps.
- DB_CYCLES=1: sw_stable follows sync2 with one cycle of delay.
- Channels are fully independent. Several channels may pulse in the same cycle. A channel cannot pulse in two consecutive cycles, because the counter restarts.
- The rise and fall bits of one channel are never both 1 in the same cycle.
- Mid-operation reset aborts any count in progress and returns all outputs to their reset values immediately.
- All outputs are registered; there is no combinational path from sw_raw to any output.

Decomposition:
- Shared package switch_pkg holds:
  - the default constants DB_CYCLES_DEFAULT (500000) and CLK_HZ (50000000);
  - a clog2 helper function, used to derive CNT_W;
  - the simulation constant DB_CYCLES_SIM (4).
- One natural sub-module: debounce_channel. It is a 1-bit synchroniser, counter and edge generator, instantiated WIDTH times in a generate loop. The top level only ORs the pulses into sw_changed.

Test Plan:
All scenarios use DB_CYCLES=4, WIDTH=2, RESET_VAL=0.
1. Reset with sw_raw=2'b11 held throughout, then release -> sw_stable=00 for edges 0-5 after release. sw_stable=11 at edge 6 after release (DB_CYCLES+2), with sw_rise=11 and sw_changed=1 for exactly one cycle. sw_fall stays 00 throughout.
2. Stable sw_stable=00, then sw_raw[0] pulsed high for 3 cycles -> sw_stable stays 00; no pulses; cnt[0] returns to 0.
3. sw_raw[1] bounces 1,0,1,0,1 one cycle each, then holds 1 -> sw_stable[1] rises exactly DB_CYCLES+2 edges after the final 0->1 transition. A single sw_rise[1] pulse is generated.
4. Stable 11, sw_raw=00 held -> sw_stable 11->00 after DB_CYCLES+2 edges, with sw_fall=11 for one cycle and sw_rise=00.
5. Channel 0 rises while channel 1 falls, raw changes on the same edge -> both pulses land in the same cycle (sw_rise=01, sw_fall=10), with a single sw_changed pulse.
6. reset_n asserted mid-count (cnt=2) with sw_raw=01 held -> outputs are 00 immediately. After release, a fresh DB_CYCLES+2 delay applies before sw_stable=01.
